uart_tx_sched: RTL and testbench

// Shares one uart_tx_top transmitter between NUM_REQ byte requesters, each with its own line config.

---
 rtl/uart_tx_sched.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one uart_tx_top transmitter among NUM_REQ byte
// requesters. Each requester has its own line configuration and baud divisor.
// A round-robin arbiter picks an owner. The owner's LCR fields and divisor are
// latched, and bytes are handed over one at a time through a holding register.
// Ownership changes only after the shift register has drained, so the LCR
// outputs never change in the middle of a character.
// Optional build macro: UART_TX_SCHED_PRIO_EN gives requester 0 fixed
// priority in IDLE. The other requesters then round-robin among themselves.
module uart_tx_sched #(
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 8,
   parameter int DIV_W     = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [8*NUM_REQ-1:0]       req_data,
   input  logic [7*NUM_REQ-1:0]       req_cfg,
   input  logic [DIV_W*NUM_REQ-1:0]   req_div,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic                       pop,
   input  logic                       sreg_empty,
   output logic                       thre,
   output logic [7:0]                 din,
   output logic                       set_break,
   output logic                       sticky_parity,
   output logic                       eps,
   output logic                       pen,
   output logic                       stb,
   output logic [1:0]                 wls,
   output logic                       baud_pulse,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id
);

   localparam int ID_W = $clog2(NUM_REQ);
   localparam int BC_W = $clog2(MAX_BURST + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GRANT,
      ST_CAPTURE,
      ST_WAIT_POP,
      ST_DRAIN
   } state_e;

   state_e           state_q, state_d;
   logic [ID_W-1:0]  grant_id_q, grant_id_d;
   logic [ID_W-1:0]  rr_q, rr_d;
   logic [BC_W-1:0]  burst_q, burst_d;
   logic [6:0]       cfg_q, cfg_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [7:0]       din_q, din_d;
   logic             thre_q, thre_d;
   logic             win_found;
   logic [ID_W-1:0]  win_id;
   logic             baud_active;

   // Arbiter: first valid requester at or after the round-robin pointer.
   always_comb begin
      // NOTE: every variable written here gets a default first; a path that
      // leaves one unassigned would infer a latch.
      win_found = 1'b0;
      win_id    = '0;
`ifdef UART_TX_SCHED_PRIO_EN
      if (req_valid[0]) begin
         win_found = 1'b1;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && ((int'(rr_q) + i) % NUM_REQ) != 0 &&
                req_valid[(int'(rr_q) + i) % NUM_REQ]) begin
               win_found = 1'b1;
               win_id    = ID_W'((int'(rr_q) + i) % NUM_REQ);
            end
         end
      end
`else
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!win_found && req_valid[(int'(rr_q) + i) % NUM_REQ]) begin
            win_found = 1'b1;
            win_id    = ID_W'((int'(rr_q) + i) % NUM_REQ);
         end
      end
`endif
   end

   // Next-state logic: FSM transitions, holding register, grant and baud counter.
   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      rr_d       = rr_q;
      burst_d    = burst_q;
      cfg_d      = cfg_q;
      div_d      = div_q;
      din_d      = din_q;
      thre_d     = thre_q;
      req_ready  = '0;

      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               grant_id_d = win_id;
               state_d    = ST_GRANT;
            end
         end
         ST_GRANT: begin
            cfg_d   = req_cfg[int'(grant_id_q)*7 +: 7];
            div_d   = req_div[int'(grant_id_q)*DIV_W +: DIV_W];
            burst_d = '0;
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (req_valid[grant_id_q]) begin
               din_d                 = req_data[int'(grant_id_q)*8 +: 8];
               thre_d                = 1'b0;
               req_ready[grant_id_q] = 1'b1;
               burst_d               = burst_q + 1'b1;
               state_d               = ST_WAIT_POP;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_WAIT_POP: begin
            if (pop) begin
               thre_d  = 1'b1;
               state_d = (burst_q < BC_W'(MAX_BURST)) ? ST_CAPTURE : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (sreg_empty && thre_q) begin
               rr_d    = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // The divisor is latched in GRANT, so the counter only runs once it is valid.
      baud_active = (state_q == ST_CAPTURE) || (state_q == ST_WAIT_POP) ||
                    (state_q == ST_DRAIN);
      if (!baud_active || cnt_q == div_q) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         grant_id_q <= '0;
         rr_q       <= '0;
         burst_q    <= '0;
         cfg_q      <= '0;
         div_q      <= '0;
         cnt_q      <= '0;
         din_q      <= '0;
         thre_q     <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments make every register sample the
         // pre-edge values, independent of statement order.
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         rr_q       <= rr_d;
         burst_q    <= burst_d;
         cfg_q      <= cfg_d;
         div_q      <= div_d;
         cnt_q      <= cnt_d;
         din_q      <= din_d;
         thre_q     <= thre_d;
      end
   end

   assign thre          = thre_q;
   assign din           = din_q;
   assign set_break     = cfg_q[6];
   assign sticky_parity = cfg_q[5];
   assign eps           = cfg_q[4];
   assign pen           = cfg_q[3];
   assign stb           = cfg_q[2];
   assign wls           = cfg_q[1:0];
   assign baud_pulse    = baud_active && (cnt_q == div_q);
   assign busy          = (state_q != ST_IDLE);
   assign grant_id      = grant_id_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed self-checking bench for uart_tx_sched.
// The expected grant order under test_prio depends on UART_TX_SCHED_PRIO_EN.
module tb_uart_tx_sched;

   localparam int NUM_REQ   = 4;
   localparam int MAX_BURST = 8;
   localparam int DIV_W     = 16;

   logic                       clk;
   logic                       rst_n;
   logic [NUM_REQ-1:0]         req_valid;
   logic [8*NUM_REQ-1:0]       req_data;
   logic [7*NUM_REQ-1:0]       req_cfg;
   logic [DIV_W*NUM_REQ-1:0]   req_div;
   logic [NUM_REQ-1:0]         req_ready;
   logic                       pop;
   logic                       sreg_empty;
   logic                       thre;
   logic [7:0]                 din;
   logic                       set_break, sticky_parity, eps, pen, stb;
   logic [1:0]                 wls;
   logic                       baud_pulse;
   logic                       busy;
   logic [$clog2(NUM_REQ)-1:0] grant_id;

   int checks = 0;
   int errors = 0;

   uart_tx_sched #(.NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST), .DIV_W(DIV_W)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_cfg(req_cfg), .req_div(req_div), .req_ready(req_ready), .pop(pop),
      .sreg_empty(sreg_empty), .thre(thre), .din(din), .set_break(set_break),
      .sticky_parity(sticky_parity), .eps(eps), .pen(pen), .stb(stb), .wls(wls),
      .baud_pulse(baud_pulse), .busy(busy), .grant_id(grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Enters reset, holds it for two edges, then releases it just after a rising edge.
   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      pop       = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Waits for one capture from requester id, checks it, then answers with a single pop.
   // The task starts and ends 1 ns after a rising edge.
   task automatic run_byte(input int id, input logic [7:0] data, input int max_wait,
                           output int lat);
      logic [NUM_REQ-1:0] exp_rdy;
      exp_rdy = 4'b0001 << id;
      lat     = 0;
      @(negedge clk);
      while (req_ready == '0 && lat < max_wait) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (req_ready !== exp_rdy) begin
         errors++;
         $display("FAIL run_byte.req_ready got %b expected %b", req_ready, exp_rdy);
      end
      checks++;
      if (grant_id !== 2'(id) || busy !== 1'b1) begin
         errors++;
         $display("FAIL run_byte.grant got id %0d busy %b expected id %0d busy 1",
                  grant_id, busy, id);
      end
      @(posedge clk);
      #1 pop = 1'b1;
      @(negedge clk);
      checks++;
      if (din !== data || thre !== 1'b0) begin
         errors++;
         $display("FAIL run_byte.din got %h thre %b expected %h thre 0", din, thre, data);
      end
      @(posedge clk);
      #1 pop = 1'b0;
   endtask

   // Waits a bounded number of cycles for the scheduler to return to IDLE.
   task automatic wait_idle();
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL wait_idle got busy %b expected 0", busy);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = 4'b1111;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (thre !== 1'b1 || busy !== 1'b0 || baud_pulse !== 1'b0 ||
          req_ready !== 4'b0000 || din !== 8'h00) begin
         errors++;
         $display("FAIL reset.outputs got thre %b busy %b baud %b rdy %b din %h",
                  thre, busy, baud_pulse, req_ready, din);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || grant_id !== 2'd0) begin
         errors++;
         $display("FAIL reset.first_grant got busy %b id %0d expected busy 1 id 0",
                  busy, grant_id);
      end
   endtask

   task automatic test_single_byte();
      int n;
      do_reset();
      sreg_empty    = 1'b0;
      req_data[7:0] = 8'hA5;
      req_cfg[6:0]  = 7'b0011111;
      req_div[15:0] = 16'd5;
      req_valid     = 4'b0001;
      @(negedge clk);   // IDLE
      @(negedge clk);   // GRANT
      checks++;
      if (req_ready !== 4'b0000 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single.grant got rdy %b busy %b expected 0000 1", req_ready, busy);
      end
      @(negedge clk);   // CAPTURE
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL single.latency got rdy %b expected 0001", req_ready);
      end
      @(posedge clk);
      #1 begin
         pop       = 1'b1;
         req_valid = 4'b0000;
      end
      @(negedge clk);
      checks++;
      if (din !== 8'hA5 || thre !== 1'b0) begin
         errors++;
         $display("FAIL single.din got %h thre %b expected a5 0", din, thre);
      end
      checks++;
      if ({set_break, sticky_parity, eps, pen, stb, wls} !== 7'b0011111) begin
         errors++;
         $display("FAIL single.lcr got %b expected 0011111",
                  {set_break, sticky_parity, eps, pen, stb, wls});
      end
      @(posedge clk);
      #1 pop = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000 || thre !== 1'b1) begin
         errors++;
         $display("FAIL single.no_second got rdy %b thre %b expected 0000 1", req_ready, thre);
      end
      n = 0;
      while (baud_pulse !== 1'b1 && n < 12) begin
         @(negedge clk);
         n++;
      end
      for (int k = 0; k < 2; k++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (baud_pulse !== 1'b1 && n < 12);
         checks++;
         if (n != 6) begin
            errors++;
            $display("FAIL single.baud_period got %0d expected 6", n);
         end
      end
      @(posedge clk);
      #1 sreg_empty = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || baud_pulse !== 1'b0) begin
         errors++;
         $display("FAIL single.idle got busy %b baud %b expected 0 0", busy, baud_pulse);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      do_reset();
      sreg_empty = 1'b0;
      req_cfg    = '0;
      req_div    = '0;
      req_valid  = 4'b0110;
      for (int k = 0; k < MAX_BURST; k++) begin
         req_data[15:8] = 8'h10 + 8'(k);
         run_byte(1, 8'h10 + 8'(k), 10, lat);
         if (k > 0) begin
            checks++;
            if (lat != 0) begin
               errors++;
               $display("FAIL b2b.pop_latency got %0d expected 0", lat);
            end
         end
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b1 || grant_id !== 2'd1 || req_ready !== 4'b0000 || thre !== 1'b1) begin
            errors++;
            $display("FAIL b2b.drain got busy %b id %0d rdy %b thre %b expected 1 1 0000 1",
                     busy, grant_id, req_ready, thre);
         end
      end
      @(posedge clk);
      #1 sreg_empty = 1'b1;
      for (int k = 0; k < MAX_BURST; k++) begin
         req_data[23:16] = 8'h20 + 8'(k);
         run_byte(2, 8'h20 + 8'(k), 10, lat);
      end
      req_data[15:8] = 8'h5A;
      run_byte(1, 8'h5A, 10, lat);
      req_valid = 4'b0000;
      wait_idle();
   endtask

   task automatic test_drop();
      int lat;
      do_reset();
      sreg_empty      = 1'b0;
      req_cfg[27:21]  = 7'b1100101;
      req_div[63:48]  = 16'd0;
      req_valid       = 4'b1000;
      for (int k = 0; k < 3; k++) begin
         req_data[31:24] = 8'hC0 + 8'(k);
         run_byte(3, 8'hC0 + 8'(k), 10, lat);
      end
      req_valid      = 4'b0000;
      req_cfg[27:21] = 7'b0000000;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL drop.no_fourth got rdy %b expected 0000", req_ready);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b1 || thre !== 1'b1 || baud_pulse !== 1'b1 ||
             {set_break, sticky_parity, eps, pen, stb, wls} !== 7'b1100101) begin
            errors++;
            $display("FAIL drop.hold got busy %b thre %b baud %b lcr %b expected 1 1 1 1100101",
                     busy, thre, baud_pulse, {set_break, sticky_parity, eps, pen, stb, wls});
         end
      end
      @(posedge clk);
      #1 sreg_empty = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || baud_pulse !== 1'b0) begin
         errors++;
         $display("FAIL drop.exit got busy %b baud %b expected 0 0", busy, baud_pulse);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      sreg_empty    = 1'b0;
      req_data[7:0] = 8'h3C;
      req_valid     = 4'b0001;
      repeat (3) @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (thre !== 1'b0 || din !== 8'h3C) begin
         errors++;
         $display("FAIL reset_mid.wait_pop got thre %b din %h expected 0 3c", thre, din);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (thre !== 1'b1 || din !== 8'h00 || busy !== 1'b0 || req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL reset_mid.async got thre %b din %h busy %b rdy %b expected 1 00 0 0000",
                  thre, din, busy, req_ready);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid.ready got %b expected 0000", req_ready);
         end
      end
      req_valid = 4'b0000;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_prio();
      int lat;
      int exp_id;
`ifdef UART_TX_SCHED_PRIO_EN
      exp_id = 0;
`else
      exp_id = 3;
`endif
      do_reset();
      sreg_empty       = 1'b1;
      req_data[23:16]  = 8'h66;
      req_data[7:0]    = 8'h01;
      req_data[31:24]  = 8'h33;
      req_valid        = 4'b0100;
      run_byte(2, 8'h66, 10, lat);
      req_valid = 4'b1001;
      run_byte(exp_id, (exp_id == 0) ? 8'h01 : 8'h33, 10, lat);
      req_valid = 4'b0000;
      wait_idle();
   endtask

   initial begin
      req_valid  = '0;
      req_data   = '0;
      req_cfg    = '0;
      req_div    = '0;
      pop        = 1'b0;
      sreg_empty = 1'b0;
      rst_n      = 1'b1;
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_drop();
      test_reset_mid();
      test_prio();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
